uart_rx_axis_fifo: RTL and testbench

- Downstream stage of the UART receiver; consumes its per-byte strobes (rx_data, rx_valid, parity_error).
- Buffers received bytes in a synchronous FIFO and presents them as an AXI4-Stream master.
- Parity status travels with each byte on tuser; a sticky overflow flag reports lost bytes to the host/CSR layer.

---
 rtl/uart_rx_axis_fifo.sv | 88 ++++++++
 tb/tb_uart_rx_axis_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis_fifo.sv
// UART receive byte FIFO with an AXI4-Stream master output and sticky overflow.
// Define UART_RX_PERR_DROP_EN to discard parity-error bytes instead of tagging them.
module uart_rx_axis_fifo #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  input  logic                 parity_error,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [CW-1:0]        fifo_count,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PERR_DROP_EN
  localparam int EW = DATA_BITS;
`else
  localparam int EW = DATA_BITS + 1;
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;
  logic          wr;
  logic          pop;
  logic          full;
  logic          wr_ok;
  logic          drop;

`ifdef UART_RX_PERR_DROP_EN
  assign wr           = rx_valid & ~parity_error;
  assign entry        = rx_data;
  assign m_axis_tdata = head;
  assign m_axis_tuser = 1'b0;
`else
  assign wr           = rx_valid | parity_error;
  assign entry        = {parity_error, rx_data};
  assign m_axis_tdata = head[DATA_BITS-1:0];
  assign m_axis_tuser = head[DATA_BITS];
`endif

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (fifo_count != '0);
  assign full          = (fifo_count == CW'(FIFO_DEPTH));
  assign pop           = m_axis_tvalid & m_axis_tready;
  // a same-cycle pop frees the slot a full FIFO needs
  assign wr_ok         = wr & (~full | pop);
  assign drop          = wr & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= fifo_count + CW'(wr_ok) - CW'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Bench for uart_rx_axis_fifo: vector table, directed corners, and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_axis_fifo;

  localparam int DB = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef UART_RX_PERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DB-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          parity_error = 1'b0;
  logic [DB-1:0] m_axis_tdata;
  logic          m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  uart_rx_axis_fifo #(
    .DATA_BITS(DB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .parity_error(parity_error),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  logic m_ovf = 1'b0;
  int pushed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: the FIFO as a bounded queue of {perr, byte}
  task automatic model_edge();
    bit mpop, mwr, full;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      return;
    end
    mpop = (q.size() != 0) && m_axis_tready;
    mwr = DROP ? (rx_valid && !parity_error) : (rx_valid || parity_error);
    full = (q.size() == DEPTH);
    if (mpop) void'(q.pop_front());
    if (mwr && (!full || mpop)) begin
      q.push_back({parity_error, rx_data});
      pushed++;
    end
    if (mwr && full && !mpop) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
  endtask

  task automatic check_model();
    chk("tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) begin
      chk("tdata", 32'(m_axis_tdata), 32'(q[0][7:0]));
      chk("tuser", 32'(m_axis_tuser), 32'(q[0][8]));
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic pe,
                       input logic [7:0] d, input logic rdy, input logic clr);
    rst = r;
    rx_valid = rv;
    parity_error = pe;
    rx_data = d;
    m_axis_tready = rdy;
    clr_overflow = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       r, rv, pe;
    logic [7:0] d;
    logic       rdy, clr;
    logic       ev;
    logic [7:0] ed;
    logic       eu;
    int         ec;
    logic       eo;
  } vec_t;

  vec_t tbl[9];
  logic [7:0] last;
  int start_push;
  int n;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h42, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h43, 1'b1, 1'b0, 1'b1, 8'h43, 1'b0, 1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, !DROP, 8'h5A, 1'b1,
               DROP ? 0 : 1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, !DROP, 8'h33, 1'b1,
               DROP ? 0 : 1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};

    #1;
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].r, tbl[i].rv, tbl[i].pe, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_tdata", i), 32'(m_axis_tdata), 32'(tbl[i].ed));
        chk($sformatf("vec%0d_tuser", i), 32'(m_axis_tuser), 32'(tbl[i].eu));
      end
    end

    // backpressure to full, then overflow and clear precedence
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'(i), 0, 0);
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    chk("full_head", 32'(m_axis_tdata), 32'h00);
    cycle(0, 1, 0, 8'hFF, 0, 0);
    chk("drop_ovf", 32'(overflow), 32'h1);
    chk("drop_count", 32'(fifo_count), 32'(DEPTH));
    cycle(0, 1, 0, 8'hEE, 0, 1);
    chk("set_wins_ovf", 32'(overflow), 32'h1);
    cycle(0, 0, 0, 8'h00, 0, 1);
    chk("clr_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_beat", 32'(m_axis_tdata), 32'(i));
      cycle(0, 0, 0, 8'h00, 1, 0);
    end
    chk("drain_empty", 32'(fifo_count), 32'h0);

    // full with simultaneous write and pop
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'(8'h10 + i), 0, 0);
    cycle(0, 1, 0, 8'hAA, 1, 0);
    chk("wp_ovf", 32'(overflow), 32'h0);
    chk("wp_count", 32'(fifo_count), 32'(DEPTH));
    last = 8'h00;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (m_axis_tvalid) last = m_axis_tdata;
      cycle(0, 0, 0, 8'h00, 1, 0);
    end
    chk("wp_last_beat", 32'(last), 32'hAA);

    // reset mid-stream, strobe in reset cycle ignored
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'(8'h60 + i), 0, 0);
    cycle(1, 1, 0, 8'h77, 0, 0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);

    // randomized traffic across pointer wrap
    start_push = pushed;
    n = 0;
    while ((pushed - start_push) < 40 && n < 1000) begin
      cycle(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      n++;
    end
    chk("rand_pushes_reached", 32'((pushed - start_push) >= 40), 32'h1);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      cycle(0, 0, 0, 8'h00, 1, 0);
      n++;
    end
    chk("rand_drained", 32'(fifo_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
